// File: rtl/seg_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg_scan_display_if
// Bundles the control inputs and the pin-side outputs of seg_scan_display.
//   show_count_d  : 1 = show games-played count, 0 = show game message
//   count_d       : binary games-played count (COUNT_W bits)
//   game_state_d  : game FSM state code (3 bits)
//   an_d          : active-low one-hot digit enables (NUM_DIGITS bits)
//   seg_d         : active-low segments {dp,g,f,e,d,c,b,a}
//   conv_busy_d   : binary-to-BCD conversion in progress
// master = game logic side, slave = display controller side.
// ---------------------------------------------------------------------------
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_W    = 10
);
    logic                  show_count_d;
    logic [COUNT_W-1:0]    count_d;
    logic [2:0]            game_state_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [7:0]            seg_d;
    logic                  conv_busy_d;

    modport master (
        output show_count_d, count_d, game_state_d,
        input  an_d, seg_d, conv_busy_d
    );

    modport slave (
        input  show_count_d, count_d, game_state_d,
        output an_d, seg_d, conv_busy_d
    );
endinterface

// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
// Multiplexed common-anode seven-segment controller. Scans NUM_DIGITS digits,
// showing either a game-state message (winner messages blink) or the
// games-played count converted to decimal by a sequential double-dabble
// converter, with leading-zero blanking and saturation to all 9s.
// Ports:
//   clk_d : system clock
//   rst_d : synchronous active-high reset
//   bus   : seg_scan_display_if slave modport (controls in, pins out)
// ---------------------------------------------------------------------------
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_W    = 10,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic              clk_d,
    input  logic              rst_d,
    seg_scan_display_if.slave bus
);

    localparam int SCAN_W      = $clog2(SCAN_DIV);
    localparam int BLINK_W     = $clog2(BLINK_DIV);
    localparam int IDX_W       = $clog2(NUM_DIGITS);
    localparam int SH_W        = $clog2(COUNT_W + 1);
    // Enough decimal digits to hold any COUNT_W-bit value.
    localparam int CONV_DIGITS = COUNT_W / 3 + 1;
    localparam int WORK_W      = 4 * CONV_DIGITS + COUNT_W;
    localparam int BCD_W       = 4 * NUM_DIGITS;
    localparam longint unsigned SAT_LIMIT = 64'(10) ** NUM_DIGITS;

    localparam logic [7:0] G_P     = 8'h8C;
    localparam logic [7:0] G_1     = 8'hF9;
    localparam logic [7:0] G_2     = 8'hA4;
    localparam logic [7:0] G_D     = 8'hA1;
    localparam logic [7:0] G_R     = 8'hAF;
    localparam logic [7:0] G_A     = 8'h88;
    localparam logic [7:0] G_W     = 8'hD5;
    localparam logic [7:0] G_DASH  = 8'hBF;
    localparam logic [7:0] G_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]     div_q,       div_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  phase_on_q,  phase_on_d;
    conv_state_t           state_q,     state_d;
    logic [COUNT_W-1:0]    snap_q,      snap_d;
    logic                  sat_q,       sat_d;
    logic [WORK_W-1:0]     work_q,      work_d;
    logic [SH_W-1:0]       shift_cnt_q, shift_cnt_d;
    logic [BCD_W-1:0]      bcd_q,       bcd_d;
    logic                  busy_q,      busy_d;
    logic [NUM_DIGITS-1:0] an_q,        an_d;
    logic [7:0]            seg_q,       seg_d;

    // ------------------------------------------------------------------
    // Glyph lookup
    // ------------------------------------------------------------------
    function automatic logic [7:0] digit_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Message glyph for digit position pos (0 = rightmost); positions
    // beyond the 4-character message are blank.
    function automatic logic [7:0] msg_glyph(input logic [2:0] st,
                                             input logic [3:0] pos);
        logic [7:0] g;
        g = G_BLANK;
        case (st)
            3'd0: case (pos)
                      4'd3:    g = G_P;
                      4'd2:    g = G_1;
                      default: g = G_BLANK;
                  endcase
            3'd1: case (pos)
                      4'd3:    g = G_P;
                      4'd2:    g = G_2;
                      default: g = G_BLANK;
                  endcase
            3'd2: case (pos)
                      4'd3:    g = G_D;
                      4'd2:    g = G_R;
                      4'd1:    g = G_A;
                      4'd0:    g = G_W;
                      default: g = G_BLANK;
                  endcase
            3'd3: case (pos)
                      4'd3:    g = G_P;
                      4'd2:    g = G_1;
                      4'd0:    g = G_W;
                      default: g = G_BLANK;
                  endcase
            3'd4: case (pos)
                      4'd3:    g = G_P;
                      4'd2:    g = G_2;
                      4'd0:    g = G_W;
                      default: g = G_BLANK;
                  endcase
            default: case (pos)
                      4'd0, 4'd1, 4'd2, 4'd3: g = G_DASH;
                      default:                g = G_BLANK;
                  endcase
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Double-dabble datapath: add 3 to each BCD nibble >= 5, binary part
    // passes through; the shift is applied in the FSM.
    // ------------------------------------------------------------------
    logic [WORK_W-1:0] work_adj;
    logic [BCD_W-1:0]  conv_bcd;

    assign work_adj[COUNT_W-1:0] = work_q[COUNT_W-1:0];

    for (genvar gi = 0; gi < CONV_DIGITS; gi++) begin : g_adj
        localparam int LO = COUNT_W + 4 * gi;
        assign work_adj[LO+3:LO] = (work_q[LO+3:LO] >= 4'd5) ?
                                   work_q[LO+3:LO] + 4'd3 : work_q[LO+3:LO];
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_conv
        if (gi < CONV_DIGITS) begin : g_live
            assign conv_bcd[4*gi+3:4*gi] = work_q[COUNT_W+4*gi+3:COUNT_W+4*gi];
        end else begin : g_zero
            assign conv_bcd[4*gi+3:4*gi] = 4'h0;
        end
    end

    // ------------------------------------------------------------------
    // Converter FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        sat_d       = sat_q;
        work_d      = work_q;
        shift_cnt_d = shift_cnt_q;
        bcd_d       = bcd_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.count_d != snap_q) begin
                    snap_d      = bus.count_d;
                    sat_d       = (64'(bus.count_d) >= SAT_LIMIT);
                    work_d      = {{(4*CONV_DIGITS){1'b0}}, bus.count_d};
                    shift_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d      = work_adj << 1;
                shift_cnt_d = shift_cnt_q + 1'b1;
                if (shift_cnt_q == SH_W'(COUNT_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The display register only ever sees a finished value.
                bcd_d   = sat_q ? {NUM_DIGITS{4'h9}} : conv_bcd;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan and blink timing
    // ------------------------------------------------------------------
    always_comb begin
        div_d       = div_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_on_d  = phase_on_q;
        if (div_q == SCAN_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end
    end

    // ------------------------------------------------------------------
    // Output selection for the currently indexed digit
    // ------------------------------------------------------------------
    // lead_zero[i]: digits i..NUM_DIGITS-1 of the BCD register are all 0.
    logic [NUM_DIGITS:0] lead_zero;
    logic [3:0]          bcd_nib [NUM_DIGITS];
    logic                blink_off;
    logic                blank_lead;

    assign lead_zero[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign bcd_nib[gi]   = bcd_q[4*gi+3:4*gi];
        assign lead_zero[gi] = lead_zero[gi+1] && (bcd_q[4*gi+3:4*gi] == 4'h0);
        assign an_d[gi]      = blink_off || (idx_q != IDX_W'(gi));
    end

    assign blink_off  = !bus.show_count_d && !phase_on_q &&
                        ((bus.game_state_d == 3'd3) || (bus.game_state_d == 3'd4));
    // Digit 0 is never blanked so a zero count still shows "0".
    assign blank_lead = (idx_q != '0) && lead_zero[idx_q];

    always_comb begin
        seg_d = G_BLANK;
        if (bus.show_count_d) begin
            seg_d = blank_lead ? G_BLANK : digit_glyph(bcd_nib[idx_q]);
        end else begin
            seg_d = msg_glyph(bus.game_state_d, 4'(idx_q));
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            div_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            sat_q       <= 1'b0;
            work_q      <= '0;
            shift_cnt_q <= '0;
            bcd_q       <= '0;
            busy_q      <= 1'b0;
            an_q        <= '1;
            seg_q       <= 8'hFF;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            state_q     <= state_d;
            snap_q      <= snap_d;
            sat_q       <= sat_d;
            work_q      <= work_d;
            shift_cnt_q <= shift_cnt_d;
            bcd_q       <= bcd_d;
            busy_q      <= busy_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.an_d        = an_q;
    assign bus.seg_d       = seg_q;
    assign bus.conv_busy_d = busy_q;

endmodule
